// File: rtl/link_scheduler_pkg.sv
// Shared NoC definitions for the link scheduler: VC count, flit format,
// flit labels and the per-VC packet state.
package noc_params;

  localparam int VC_NUM  = 2;
  localparam int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int DATA_W  = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t          flit_label;
    logic [VC_SIZE-1:0]   vc_id;
    logic [DATA_W-1:0]    data;
  } flit_t;

  // Per-VC packet state: IDLE = no packet open, ACTIVE = head sent, tail pending.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } vc_state_t;

  // HEAD and HEADTAIL both open a packet and need an IDLE, allocatable VC.
  function automatic logic opens_packet(flit_label_t label);
    return (label == HEAD) || (label == HEADTAIL);
  endfunction

endpackage

// File: rtl/link_scheduler_if.sv
// Bundle of the VC-side handshake and the router-to-router link signals.
// master: the scheduler; slave: the upstream VCs / downstream router model.
interface link_scheduler_if
  import noc_params::*;
#(
  parameter int VC_NUM = noc_params::VC_NUM
) ();

  logic  [VC_NUM-1:0] req_i;
  flit_t [VC_NUM-1:0] flit_i;
  logic  [VC_NUM-1:0] grant_o;
  flit_t              data_o;
  logic               is_valid_o;
  logic  [VC_NUM-1:0] is_on_off_i;
  logic  [VC_NUM-1:0] is_allocatable_i;

  modport master (
    input  req_i, flit_i, is_on_off_i, is_allocatable_i,
    output grant_o, data_o, is_valid_o
  );

  modport slave (
    output req_i, flit_i, is_on_off_i, is_allocatable_i,
    input  grant_o, data_o, is_valid_o
  );

endinterface

// File: rtl/link_scheduler_arbiter.sv
// Round-robin arbiter: one-hot grant among N requests, priority starting at
// the index after the last grant. Pointer holds when nothing is granted.
module round_robin_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Scan from the pointer and grant the first requester; compute next pointer.
  always_comb begin
    int          idx;
    logic        found;
    logic [PW-1:0] sel;
    // NOTE: every output gets a default before any condition so no latch is inferred.
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= N) idx = idx - N;
        sel = PW'(idx);
        if (!found && req[sel]) begin
          found      = 1'b1;
          grant[sel] = 1'b1;
          ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
        end
      end
    end
  end

  // Pointer register; first priority to index 0 after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/link_scheduler.sv
// Link scheduler: picks one VC per cycle for a shared router-to-router link,
// enforcing per-VC packet framing and downstream on/off / allocation flow
// control. Granted flit is registered onto the link one cycle later.
// Optional build macro LINK_STATS_EN adds saturating flit and stall counters.
module link_scheduler
  import noc_params::*;
#(
  parameter int VC_NUM = noc_params::VC_NUM
) (
  input  logic              clk,
  input  logic              rst,
  link_scheduler_if.master  bus,
  output logic              proto_err_o
`ifdef LINK_STATS_EN
  ,
  output logic [15:0]       flit_cnt_o,
  output logic [15:0]       stall_cnt_o
`endif
);

  logic      [VC_NUM-1:0] eligible;
  logic      [VC_NUM-1:0] violation;
  logic      [VC_NUM-1:0] grant;
  vc_state_t [VC_NUM-1:0] state_q;
  vc_state_t [VC_NUM-1:0] state_d;
  flit_t                  sel_flit;
  flit_t                  data_q;
  logic                   valid_q;
  logic                   err_q;

  // Eligibility and protocol-violation detection per VC.
  always_comb begin
    flit_label_t label;
    logic        legal;
    logic        bad;
    eligible  = '0;
    violation = '0;
    label     = HEAD;
    legal     = 1'b0;
    bad       = 1'b0;
    for (int v = 0; v < VC_NUM; v++) begin
      label = bus.flit_i[v].flit_label;
      if (opens_packet(label)) begin
        legal = (state_q[v] == IDLE) && bus.is_allocatable_i[v];
        bad   = (state_q[v] == ACTIVE);
      end else begin
        legal = (state_q[v] == ACTIVE);
        bad   = (state_q[v] == IDLE);
      end
      eligible[v]  = bus.req_i[v] && bus.is_on_off_i[v] && legal;
      violation[v] = bus.req_i[v] && bad;
    end
  end

  round_robin_arbiter #(
    .N (VC_NUM)
  ) u_arbiter (
    .clk   (clk),
    .rst   (rst),
    .req   (eligible),
    .grant (grant)
  );

  assign bus.grant_o = grant;

  // Select the granted flit and stamp it with the granted VC index.
  always_comb begin
    sel_flit = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (grant[v]) begin
        sel_flit       = bus.flit_i[v];
        sel_flit.vc_id = VC_SIZE'(v);
      end
    end
  end

  // Per-VC packet state transitions on grant.
  always_comb begin
    state_d = state_q;
    for (int v = 0; v < VC_NUM; v++) begin
      if (grant[v]) begin
        case (bus.flit_i[v].flit_label)
          HEAD:    state_d[v] = ACTIVE;
          TAIL:    state_d[v] = IDLE;
          default: state_d[v] = state_q[v];
        endcase
      end
    end
  end

  // Per-VC state register; reset discards any open packet.
  always_ff @(posedge clk) begin
    // NOTE: the VC state vector is a few flops, not a RAM, so it is reset explicitly.
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) state_q[v] <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Link output register and sticky protocol-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= |grant;
      if (|grant)     data_q <= sel_flit;
      if (|violation) err_q  <= 1'b1;
    end
  end

  assign bus.data_o     = data_q;
  assign bus.is_valid_o = valid_q;
  assign proto_err_o    = err_q;

`ifdef LINK_STATS_EN
  logic [15:0] flit_cnt_q;
  logic [15:0] stall_cnt_q;

  // Saturating counters: flits placed on the link, and requesting cycles without a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (valid_q && (flit_cnt_q != 16'hFFFF))
        flit_cnt_q <= flit_cnt_q + 16'd1;
      if ((|bus.req_i) && !(|grant) && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign flit_cnt_o  = flit_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_link_scheduler.sv
// Directed bench for link_scheduler with VC_NUM = 2. Inputs change 1 time unit
// after the rising edge; outputs are sampled 1 time unit later.
module tb_link_scheduler;
  import noc_params::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic proto_err;
  int   total = 0;
  int   bad   = 0;

`ifdef LINK_STATS_EN
  logic [15:0] flit_cnt;
  logic [15:0] stall_cnt;
`endif

  link_scheduler_if bus ();

  link_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .proto_err_o (proto_err)
`ifdef LINK_STATS_EN
    ,
    .flit_cnt_o  (flit_cnt),
    .stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic flit_t mk(input flit_label_t l, input logic [VC_SIZE-1:0] id,
                               input logic [15:0] d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = id;
    f.data       = d;
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input flit_t f0, input flit_t f1,
                       input logic [1:0] onoff, input logic [1:0] alloc);
    bus.req_i            = req;
    bus.flit_i[0]        = f0;
    bus.flit_i[1]        = f1;
    bus.is_on_off_i      = onoff;
    bus.is_allocatable_i = alloc;
    #1;
  endtask

  initial begin
    flit_t nf;
    nf = mk(HEADTAIL, 1'b0, 16'h0000);

    // Reset: no grant even with everything requesting and eligible.
    drive(2'b11, mk(HEADTAIL, 1'b0, 16'h0001), mk(HEADTAIL, 1'b0, 16'h0002), 2'b11, 2'b11);
    check("rst_grant", 32'(bus.grant_o), 32'h0);
    tick();
    drive(2'b11, mk(HEADTAIL, 1'b0, 16'h0001), mk(HEADTAIL, 1'b0, 16'h0002), 2'b11, 2'b11);
    check("rst_grant_held", 32'(bus.grant_o), 32'h0);
    check("rst_valid", 32'(bus.is_valid_o), 32'h0);
    check("rst_data", 32'(bus.data_o), 32'h0);
    check("rst_err", 32'(proto_err), 32'h0);
    tick();
    rst = 1'b0;
    drive(2'b00, nf, nf, 2'b11, 2'b11);
    tick();

    // VC1 sends HEAD, BODY, TAIL back to back; vc_id field rewritten to 1.
    drive(2'b10, nf, mk(HEAD, 1'b0, 16'h0A11), 2'b11, 2'b11);
    check("pkt_head_grant", 32'(bus.grant_o), 32'h2);
    tick();
    drive(2'b10, nf, mk(BODY, 1'b0, 16'h0B22), 2'b11, 2'b11);
    check("pkt_body_grant", 32'(bus.grant_o), 32'h2);
    check("pkt_head_valid", 32'(bus.is_valid_o), 32'h1);
    check("pkt_head_data", 32'(bus.data_o), 32'(mk(HEAD, 1'b1, 16'h0A11)));
    tick();
    drive(2'b10, nf, mk(TAIL, 1'b0, 16'h0C33), 2'b11, 2'b11);
    check("pkt_tail_grant", 32'(bus.grant_o), 32'h2);
    check("pkt_body_data", 32'(bus.data_o), 32'(mk(BODY, 1'b1, 16'h0B22)));
    tick();
    drive(2'b00, nf, nf, 2'b11, 2'b11);
    check("pkt_idle_grant", 32'(bus.grant_o), 32'h0);
    check("pkt_tail_valid", 32'(bus.is_valid_o), 32'h1);
    check("pkt_tail_data", 32'(bus.data_o), 32'(mk(TAIL, 1'b1, 16'h0C33)));
    tick();
    check("gap_valid", 32'(bus.is_valid_o), 32'h0);
    check("gap_data_hold", 32'(bus.data_o), 32'(mk(TAIL, 1'b1, 16'h0C33)));

    // VC1 is IDLE again: a HEADTAIL is accepted.
    drive(2'b10, nf, mk(HEADTAIL, 1'b0, 16'h0D44), 2'b11, 2'b11);
    check("vc1_idle_grant", 32'(bus.grant_o), 32'h2);
    tick();

    // Both VCs stream HEADTAIL: grants alternate 0,1,0,1 from pointer 0.
    drive(2'b11, mk(HEADTAIL, 1'b1, 16'h1000), mk(HEADTAIL, 1'b0, 16'h1001), 2'b11, 2'b11);
    check("rr_g1", 32'(bus.grant_o), 32'h1);
    check("rr_d0", 32'(bus.data_o), 32'(mk(HEADTAIL, 1'b1, 16'h0D44)));
    tick();
    check("rr_g2", 32'(bus.grant_o), 32'h2);
    check("rr_d1", 32'(bus.data_o), 32'(mk(HEADTAIL, 1'b0, 16'h1000)));
    tick();
    check("rr_g3", 32'(bus.grant_o), 32'h1);
    check("rr_d2", 32'(bus.data_o), 32'(mk(HEADTAIL, 1'b1, 16'h1001)));
    check("rr_v2", 32'(bus.is_valid_o), 32'h1);
    tick();
    check("rr_g4", 32'(bus.grant_o), 32'h2);
    check("rr_d3", 32'(bus.data_o), 32'(mk(HEADTAIL, 1'b0, 16'h1000)));
    tick();
    drive(2'b00, nf, nf, 2'b11, 2'b11);
    check("rr_d4", 32'(bus.data_o), 32'(mk(HEADTAIL, 1'b1, 16'h1001)));
    check("rr_v4", 32'(bus.is_valid_o), 32'h1);
    tick();

    // VC0 HEAD blocked by allocation for 5 cycles, granted on the 6th.
    for (int c = 0; c < 5; c++) begin
      drive(2'b01, mk(HEAD, 1'b1, 16'h2000), nf, 2'b11, 2'b10);
      check("alloc_block", 32'(bus.grant_o), 32'h0);
      tick();
    end
    drive(2'b01, mk(HEAD, 1'b1, 16'h2000), nf, 2'b11, 2'b11);
    check("alloc_block_valid", 32'(bus.is_valid_o), 32'h0);
    check("alloc_grant", 32'(bus.grant_o), 32'h1);
    tick();

    // VC0 mid-packet with on/off low for 3 cycles; VC1 HEADTAIL takes the link.
    drive(2'b11, mk(BODY, 1'b1, 16'h3000), mk(HEADTAIL, 1'b0, 16'h3001), 2'b10, 2'b11);
    check("alloc_data", 32'(bus.data_o), 32'(mk(HEAD, 1'b0, 16'h2000)));
    check("alloc_valid", 32'(bus.is_valid_o), 32'h1);
    check("onoff_g1", 32'(bus.grant_o), 32'h2);
    tick();
    check("onoff_g2", 32'(bus.grant_o), 32'h2);
    tick();
    check("onoff_g3", 32'(bus.grant_o), 32'h2);
    tick();
    drive(2'b01, mk(BODY, 1'b1, 16'h3000), nf, 2'b11, 2'b11);
    check("onoff_resend", 32'(bus.grant_o), 32'h1);
    check("onoff_vc1_data", 32'(bus.data_o), 32'(mk(HEADTAIL, 1'b1, 16'h3001)));
    tick();
    drive(2'b01, mk(TAIL, 1'b1, 16'h3002), nf, 2'b11, 2'b11);
    check("onoff_tail_grant", 32'(bus.grant_o), 32'h1);
    check("onoff_body_data", 32'(bus.data_o), 32'(mk(BODY, 1'b0, 16'h3000)));
    tick();
    drive(2'b00, nf, nf, 2'b11, 2'b11);
    check("onoff_tail_data", 32'(bus.data_o), 32'(mk(TAIL, 1'b0, 16'h3002)));
    check("no_err_yet", 32'(proto_err), 32'h0);
    tick();

    // BODY on IDLE VC1: never granted, sticky error one cycle later.
    drive(2'b10, nf, mk(BODY, 1'b0, 16'h4000), 2'b11, 2'b11);
    check("perr_grant", 32'(bus.grant_o), 32'h0);
    check("perr_before", 32'(proto_err), 32'h0);
    tick();
    check("perr_grant2", 32'(bus.grant_o), 32'h0);
    check("perr_set", 32'(proto_err), 32'h1);
    drive(2'b00, nf, nf, 2'b11, 2'b11);
    tick();
    tick();
    check("perr_sticky", 32'(proto_err), 32'h1);

    // Reset clears error and outputs.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst2_err", 32'(proto_err), 32'h0);
    check("rst2_valid", 32'(bus.is_valid_o), 32'h0);
    check("rst2_data", 32'(bus.data_o), 32'h0);
`ifdef LINK_STATS_EN
    check("rst2_flit_cnt", 32'(flit_cnt), 32'h0);
`endif

    // Open a packet on VC0, reset mid-packet, then BODY is illegal.
    drive(2'b01, mk(HEAD, 1'b1, 16'h5000), nf, 2'b11, 2'b11);
    check("mid_head_grant", 32'(bus.grant_o), 32'h1);
    tick();
    rst = 1'b1;
    drive(2'b01, mk(BODY, 1'b1, 16'h5001), nf, 2'b11, 2'b11);
    check("mid_rst_grant", 32'(bus.grant_o), 32'h0);
    tick();
    rst = 1'b0;
    drive(2'b01, mk(BODY, 1'b1, 16'h5001), nf, 2'b11, 2'b11);
    check("mid_body_grant", 32'(bus.grant_o), 32'h0);
    check("mid_err_before", 32'(proto_err), 32'h0);
`ifdef LINK_STATS_EN
    check("mid_flit_cnt", 32'(flit_cnt), 32'h0);
`endif
    tick();
    check("mid_err_set", 32'(proto_err), 32'h1);
    drive(2'b01, mk(HEAD, 1'b1, 16'h5002), nf, 2'b11, 2'b11);
    check("mid_head_again", 32'(bus.grant_o), 32'h1);
    tick();
    drive(2'b00, nf, nf, 2'b11, 2'b11);
    check("mid_head_data", 32'(bus.data_o), 32'(mk(HEAD, 1'b0, 16'h5002)));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
